// File: rtl/cordic_sequencer_if.sv
// rtl/cordic_sequencer_if.sv - host and chain signal bundle for the CORDIC sequencer
//
// Purpose: carries the start/busy/done handshake, operand and result words,
//          and the signals to and from the external two-stage CORDIC chain.
// Modports:
//   slave  - the sequencer: samples start/x_in/y_in/z_in/chain_*_res,
//            drives busy/done/*_out/chain_x/y/z/atan0/atan1/stages
//   master - the host plus chain side: the opposite directions
interface cordic_sequencer_if;
   logic               start;
   logic signed [17:0] x_in;
   logic signed [17:0] y_in;
   logic signed [17:0] z_in;
   logic               busy;
   logic               done;
   logic signed [17:0] x_out;
   logic signed [17:0] y_out;
   logic signed [17:0] z_out;
   logic signed [17:0] chain_x;
   logic signed [17:0] chain_y;
   logic signed [17:0] chain_z;
   logic signed [17:0] chain_atan0;
   logic signed [17:0] chain_atan1;
   logic        [3:0]  chain_stages;
   logic signed [17:0] chain_x_res;
   logic signed [17:0] chain_y_res;
   logic signed [17:0] chain_z_res;

   modport slave (
      input  start, x_in, y_in, z_in,
      input  chain_x_res, chain_y_res, chain_z_res,
      output busy, done, x_out, y_out, z_out,
      output chain_x, chain_y, chain_z, chain_atan0, chain_atan1, chain_stages
   );

   modport master (
      output start, x_in, y_in, z_in,
      output chain_x_res, chain_y_res, chain_z_res,
      input  busy, done, x_out, y_out, z_out,
      input  chain_x, chain_y, chain_z, chain_atan0, chain_atan1, chain_stages
   );
endinterface

// File: rtl/cordic_sequencer.sv
// rtl/cordic_sequencer.sv - iterative rotation-mode controller for a two-stage CORDIC chain
//
// Purpose: holds the x/y/z working registers and cycles them through an
//          external chain that performs two CORDIC rotations per clock. One
//          operation takes NUM_PAIRS clocks; the chain is told which pair of
//          stages to apply and the arctangent constants for that pair.
// Parameters:
//   NUM_PAIRS  - rotation pairs per operation (1..8)
//   PRE_ROTATE - 1 folds angles beyond +/-pi/2 back by pi at load time
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset
//   bus.start  - request, accepted only in IDLE or DONE
//   bus.x_in/y_in/z_in   - initial vector and angle (z in Q3.15 radians)
//   bus.busy   - high while iterating
//   bus.done   - result valid, held until the next accepted start
//   bus.x_out/y_out/z_out - working registers (result while done=1)
//   bus.chain_x/y/z      - working registers to the chain
//   bus.chain_stages     - first stage index of the current pair
//   bus.chain_atan0/1    - atan(2^-stages), atan(2^-(stages+1))
//   bus.chain_x/y/z_res  - chain results for the current pair
module cordic_sequencer #(
   parameter int NUM_PAIRS  = 8,
   parameter bit PRE_ROTATE = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   cordic_sequencer_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [2:0]         LAST_STEP = 3'(NUM_PAIRS - 1);
   localparam logic signed [17:0] HALF_PI   = 18'sd51472;
   localparam logic signed [18:0] PI_19     = 19'sd102944;
   localparam logic signed [17:0] MAX_POS   = 18'sd131071;
   localparam logic signed [17:0] MIN_NEG   = -18'sd131072;

   state_t             r_state;
   logic        [2:0]  r_step;
   logic signed [17:0] r_x;
   logic signed [17:0] r_y;
   logic signed [17:0] r_z;
   logic               r_busy;
   logic               r_done;

   // round(atan(2^-i) * 32768), the Q3.15 angle removed by stage i
   function automatic logic signed [17:0] atan_lut(input logic [3:0] i_idx);
      logic signed [17:0] v;
      case (i_idx)
         4'd0:    v = 18'sd25736;
         4'd1:    v = 18'sd15193;
         4'd2:    v = 18'sd8027;
         4'd3:    v = 18'sd4075;
         4'd4:    v = 18'sd2045;
         4'd5:    v = 18'sd1024;
         4'd6:    v = 18'sd512;
         4'd7:    v = 18'sd256;
         4'd8:    v = 18'sd128;
         4'd9:    v = 18'sd64;
         4'd10:   v = 18'sd32;
         4'd11:   v = 18'sd16;
         4'd12:   v = 18'sd8;
         4'd13:   v = 18'sd4;
         4'd14:   v = 18'sd2;
         default: v = 18'sd1;
      endcase
      return v;
   endfunction

   // The most negative value has no positive twin; clamp it instead of wrapping.
   function automatic logic signed [17:0] sat_neg(input logic signed [17:0] i_v);
      return (i_v == MIN_NEG) ? MAX_POS : -i_v;
   endfunction

   // ------------------------------------------------------------------
   // Quadrant pre-rotation at load time. Rotating by pi is a pure sign
   // flip of x and y, so an angle outside +/-pi/2 is brought back into the
   // CORDIC convergence range by negating the vector and moving z by pi.
   // Only one correction is applied; angles beyond +/-pi are not wrapped.
   // ------------------------------------------------------------------
   logic               w_z_above;
   logic               w_z_below;
   logic               w_pre;
   logic signed [18:0] w_z_ext;
   logic signed [18:0] w_z_fixed;
   logic signed [17:0] w_load_x;
   logic signed [17:0] w_load_y;
   logic signed [17:0] w_load_z;

   assign w_z_above = (bus.z_in > HALF_PI);
   assign w_z_below = (bus.z_in < -HALF_PI);
   assign w_pre     = PRE_ROTATE && (w_z_above || w_z_below);
   assign w_z_ext   = {bus.z_in[17], bus.z_in};
   // 19-bit intermediate keeps the sum exact; the result fits 18 bits for |z_in| <= pi
   assign w_z_fixed = w_z_above ? (w_z_ext - PI_19) : (w_z_ext + PI_19);

   assign w_load_x  = w_pre ? sat_neg(bus.x_in) : bus.x_in;
   assign w_load_y  = w_pre ? sat_neg(bus.y_in) : bus.y_in;
   assign w_load_z  = w_pre ? w_z_fixed[17:0]   : bus.z_in;

   // ------------------------------------------------------------------
   // Sequencer: the step counter picks which stage pair the chain applies.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_step  <= 3'd0;
         r_x     <= 18'sd0;
         r_y     <= 18'sd0;
         r_z     <= 18'sd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  r_x     <= w_load_x;
                  r_y     <= w_load_y;
                  r_z     <= w_load_z;
                  r_step  <= 3'd0;
                  r_state <= S_RUN;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            S_RUN: begin
               // start is deliberately not looked at here: no queueing, no restart
               r_x <= bus.chain_x_res;
               r_y <= bus.chain_y_res;
               r_z <= bus.chain_z_res;
               if (r_step == LAST_STEP) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_step <= r_step + 3'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Chain drive. Outside RUN the stage index and constants are forced to
   // zero so the chain sees a quiet, well-defined input.
   // ------------------------------------------------------------------
   logic               w_run;
   logic        [3:0]  w_stage0;
   logic        [3:0]  w_stage1;

   assign w_run    = (r_state == S_RUN);
   assign w_stage0 = {r_step, 1'b0};
   assign w_stage1 = {r_step, 1'b1};

   assign bus.chain_x      = r_x;
   assign bus.chain_y      = r_y;
   assign bus.chain_z      = r_z;
   assign bus.chain_stages = w_run ? w_stage0 : 4'd0;
   assign bus.chain_atan0  = w_run ? atan_lut(w_stage0) : 18'sd0;
   assign bus.chain_atan1  = w_run ? atan_lut(w_stage1) : 18'sd0;

   assign bus.x_out = r_x;
   assign bus.y_out = r_y;
   assign bus.z_out = r_z;
   assign bus.busy  = r_busy;
   assign bus.done  = r_done;

endmodule

// File: tb/tb_cordic_sequencer.sv
// tb/tb_cordic_sequencer.sv - directed scoreboard bench for cordic_sequencer
module tb_cordic_sequencer;

   localparam int TBL [16] = '{25736, 15193, 8027, 4075, 2045, 1024, 512, 256,
                               128, 64, 32, 16, 8, 4, 2, 1};

   logic clk = 1'b0;
   logic rst;
   logic r_start;
   logic sel4;
   logic signed [17:0] x_in, y_in, z_in;

   int checks   = 0;
   int failures = 0;
   logic [53:0] sb_q [$];

   always #5 clk = ~clk;

   cordic_sequencer_if if8 ();
   cordic_sequencer_if if4 ();

   cordic_sequencer #(.NUM_PAIRS(8), .PRE_ROTATE(1'b1)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
   cordic_sequencer #(.NUM_PAIRS(4), .PRE_ROTATE(1'b1)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

   // one CORDIC rotation-mode stage, 18-bit wrapping arithmetic
   function automatic logic [53:0] stage(input logic signed [17:0] x, input logic signed [17:0] y,
                                         input logic signed [17:0] z, input int sh,
                                         input logic signed [17:0] a);
      logic signed [17:0] xs, ys;
      xs = x >>> sh;
      ys = y >>> sh;
      if (z >= 0) return {x - ys, y + xs, z - a};
      else        return {x + ys, y - xs, z + a};
   endfunction

   // external chain models, driven by each DUT's stage index and constants
   logic [53:0] c8a, c8b, c4a, c4b;
   always_comb begin
      c8a = stage(if8.chain_x, if8.chain_y, if8.chain_z, int'(if8.chain_stages), if8.chain_atan0);
      c8b = stage(c8a[53:36], c8a[35:18], c8a[17:0], int'(if8.chain_stages) + 1, if8.chain_atan1);
      c4a = stage(if4.chain_x, if4.chain_y, if4.chain_z, int'(if4.chain_stages), if4.chain_atan0);
      c4b = stage(c4a[53:36], c4a[35:18], c4a[17:0], int'(if4.chain_stages) + 1, if4.chain_atan1);
   end

   assign if8.chain_x_res = c8b[53:36];
   assign if8.chain_y_res = c8b[35:18];
   assign if8.chain_z_res = c8b[17:0];
   assign if4.chain_x_res = c4b[53:36];
   assign if4.chain_y_res = c4b[35:18];
   assign if4.chain_z_res = c4b[17:0];

   assign if8.start = r_start & ~sel4;
   assign if4.start = r_start & sel4;
   assign if8.x_in = x_in;
   assign if8.y_in = y_in;
   assign if8.z_in = z_in;
   assign if4.x_in = x_in;
   assign if4.y_in = y_in;
   assign if4.z_in = z_in;

   // view of whichever DUT is under test
   logic               busy_v, done_v;
   logic signed [17:0] xo_v, yo_v, zo_v, a0_v, a1_v;
   logic        [3:0]  stg_v;
   always_comb begin
      busy_v = sel4 ? if4.busy         : if8.busy;
      done_v = sel4 ? if4.done         : if8.done;
      xo_v   = sel4 ? if4.x_out        : if8.x_out;
      yo_v   = sel4 ? if4.y_out        : if8.y_out;
      zo_v   = sel4 ? if4.z_out        : if8.z_out;
      a0_v   = sel4 ? if4.chain_atan0  : if8.chain_atan0;
      a1_v   = sel4 ? if4.chain_atan1  : if8.chain_atan1;
      stg_v  = sel4 ? if4.chain_stages : if8.chain_stages;
   end

   function automatic logic [53:0] ref_load(input int x, input int y, input int z);
      int lx, ly, lz;
      lx = x; ly = y; lz = z;
      if (z > 51472 || z < -51472) begin
         lx = (x == -131072) ? 131071 : -x;
         ly = (y == -131072) ? 131071 : -y;
         lz = (z > 0) ? z - 102944 : z + 102944;
      end
      return {18'(lx), 18'(ly), 18'(lz)};
   endfunction

   function automatic logic [53:0] ref_run(input logic [53:0] ld, input int n);
      logic [53:0] s;
      s = ld;
      for (int i = 0; i < 2 * n; i++)
         s = stage(s[53:36], s[35:18], s[17:0], i, 18'(TBL[i]));
      return s;
   endfunction

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_tol(input string tag, input logic signed [31:0] obs,
                            input int exp, input int tol);
      checks++;
      assert (obs >= exp - tol && obs <= exp + tol) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
      end
   endtask

   // One operation; glitch >= 0 pulses start again during that RUN cycle.
   task automatic op(input int x, input int y, input int z, input int glitch);
      int n;
      logic [53:0] ld, exp;
      n  = sel4 ? 4 : 8;
      ld = ref_load(x, y, z);
      sb_q.push_back(ref_run(ld, n));
      @(negedge clk);
      x_in = 18'(x); y_in = 18'(y); z_in = 18'(z);
      r_start = 1'b1;
      @(negedge clk);
      r_start = 1'b0;
      for (int c = 0; c < n; c++) begin
         check("busy_run", busy_v, 1);
         check("done_run", done_v, 0);
         check("stages", stg_v, 2 * c);
         check("atan0", a0_v, TBL[2 * c]);
         check("atan1", a1_v, TBL[2 * c + 1]);
         if (c == 0) begin
            check("load_x", xo_v, $signed(ld[53:36]));
            check("load_y", yo_v, $signed(ld[35:18]));
            check("load_z", zo_v, $signed(ld[17:0]));
         end
         if (c == glitch) begin
            x_in = 18'sd5000; y_in = 18'sd5000; z_in = 18'sd30000;
            r_start = 1'b1;
         end
         @(negedge clk);
         r_start = 1'b0;
      end
      check("done_end", done_v, 1);
      check("busy_end", busy_v, 0);
      check("stages_idle", stg_v, 0);
      check("atan0_idle", a0_v, 0);
      check("sb_nonempty", sb_q.size(), 1);
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 54'd0;
      check("res_x", xo_v, $signed(exp[53:36]));
      check("res_y", yo_v, $signed(exp[35:18]));
      check("res_z", zo_v, $signed(exp[17:0]));
   endtask

   initial begin
      logic signed [17:0] held_x;
      rst = 1'b1; r_start = 1'b0; sel4 = 1'b0;
      x_in = '0; y_in = '0; z_in = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_busy", if8.busy, 0);
      check("rst_done", if8.done, 0);
      check("rst_x", if8.x_out, 0);
      check("rst_y", if8.y_out, 0);
      check("rst_z", if8.z_out, 0);
      check("rst_stages", if8.chain_stages, 0);
      check("rst_atan1", if8.chain_atan1, 0);
      check("rst_busy4", if4.busy, 0);

      op(19898, 0, 0, -1);
      check_tol("z0_x", xo_v, 32768, 16);
      check_tol("z0_y", yo_v, 0, 16);
      check_tol("z0_z", zo_v, 0, 4);
      held_x = xo_v;
      @(negedge clk);
      check("hold_done", done_v, 1);
      check("hold_busy", busy_v, 0);
      check("hold_x", xo_v, held_x);

      op(19898, 0, 51472, -1);
      check_tol("hpi_x", xo_v, 0, 16);
      check_tol("hpi_y", yo_v, 32768, 16);

      op(19898, 0, -51472, -1);
      check_tol("nhpi_x", xo_v, 0, 16);
      check_tol("nhpi_y", yo_v, -32768, 16);

      op(19898, 0, 102944, -1);
      check_tol("pi_x", xo_v, -32768, 16);
      check_tol("pi_y", yo_v, 0, 16);

      op(19898, 0, -102944, -1);
      check_tol("npi_x", xo_v, -32768, 16);
      check_tol("npi_y", yo_v, 0, 16);

      op(10000, -2000, 51473, -1);
      op(-131072, -131072, 102944, -1);

      op(19898, 0, 0, 3);
      check_tol("glitch_x", xo_v, 32768, 16);
      check_tol("glitch_y", yo_v, 0, 16);

      op(15000, 7000, -20000, -1);

      // reset in the middle of a run
      @(negedge clk);
      x_in = 18'sd19898; y_in = 18'sd0; z_in = 18'sd0;
      r_start = 1'b1;
      @(negedge clk);
      r_start = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_stage", stg_v, 8);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", busy_v, 0);
      check("abort_done", done_v, 0);
      check("abort_x", xo_v, 0);
      check("abort_y", yo_v, 0);
      check("abort_z", zo_v, 0);
      check("abort_stages", stg_v, 0);

      // reset wins over start
      rst = 1'b1; r_start = 1'b1;
      @(negedge clk);
      rst = 1'b0; r_start = 1'b0;
      check("rs_busy", busy_v, 0);
      check("rs_x", xo_v, 0);
      @(negedge clk);
      check("rs_busy2", busy_v, 0);
      check("rs_done2", done_v, 0);

      // four-pair build
      sel4 = 1'b1;
      op(19898, 0, 0, -1);
      op(12000, 3000, 90000, -1);

      check("sb_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
